// File: rtl/mips_run_ctrl.sv
// Run controller for MIPS32 core bring-up: reset hold, run-cycle count, halt-based completion, watchdog.
// Optional post-halt drain phase enabled by defining HALT_DRAIN_EN.

module mips_run_lane (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic halt,
  output logic halted,
  output logic seen
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          halted <= 1'b0;
    else if (clr)       halted <= 1'b0;
    else if (en & halt) halted <= 1'b1;
  end

  // A halt arriving this cycle counts toward completion without waiting a cycle.
  assign seen = halted | halt;
endmodule

module mips_run_ctrl #(
  parameter int NUM_CH       = 1,
  parameter int RESET_CYCLES = 2,
  parameter int MAX_CYCLES   = 1000,
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [NUM_CH-1:0] halt_i,
  output logic [NUM_CH-1:0] core_reset,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [NUM_CH-1:0] halted,
  output logic              busy,
  output logic              done,
  output logic              timeout
);
  localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HW-1:0]    HOLD_LAST = HW'(RESET_CYCLES - 1);
  localparam bit               WD_EN     = (MAX_CYCLES != 0);
  localparam logic [CNT_W-1:0] MAX_LAST  = CNT_W'(MAX_CYCLES - 1);

`ifdef HALT_DRAIN_EN
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam bit            DRAIN_ON   = (DRAIN_CYCLES > 0);
  typedef enum logic [2:0] {S_IDLE, S_HOLD, S_RUN, S_DONE, S_TIMEOUT, S_DRAIN} state_t;
  logic [DW-1:0] drain_cnt;
`else
  typedef enum logic [2:0] {S_IDLE, S_HOLD, S_RUN, S_DONE, S_TIMEOUT} state_t;
`endif

  state_t            state;
  logic [HW-1:0]     hold_cnt;
  logic [NUM_CH-1:0] seen;
  logic              launch, run_en, all_halt;

  assign launch   = start & ((state == S_IDLE) | (state == S_DONE) | (state == S_TIMEOUT));
  assign run_en   = (state == S_RUN);
  assign all_halt = &seen;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    mips_run_lane u_lane (
      .clk    (clk),
      .reset  (reset),
      .clr    (launch),
      .en     (run_en),
      .halt   (halt_i[i]),
      .halted (halted[i]),
      .seen   (seen[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      core_reset  <= '1;
      cycle_count <= '0;
      hold_cnt    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
`ifdef HALT_DRAIN_EN
      drain_cnt   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE, S_TIMEOUT: begin
          if (start) begin
            state       <= S_HOLD;
            core_reset  <= '1;
            cycle_count <= '0;
            hold_cnt    <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
            timeout     <= 1'b0;
          end
        end
        S_HOLD: begin
          hold_cnt <= hold_cnt + 1'b1;
          if (hold_cnt == HOLD_LAST) begin
            state      <= S_RUN;
            core_reset <= '0;
          end
        end
        S_RUN: begin
          cycle_count <= cycle_count + 1'b1;
          // Completion beats the watchdog when both land on the same cycle.
          if (all_halt) begin
`ifdef HALT_DRAIN_EN
            if (DRAIN_ON) begin
              state     <= S_DRAIN;
              drain_cnt <= '0;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
`else
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
`endif
          end else if (WD_EN && (cycle_count == MAX_LAST)) begin
            state      <= S_TIMEOUT;
            timeout    <= 1'b1;
            busy       <= 1'b0;
            core_reset <= '1;
          end
        end
`ifdef HALT_DRAIN_EN
        S_DRAIN: begin
          cycle_count <= cycle_count + 1'b1;
          drain_cnt   <= drain_cnt + 1'b1;
          if (drain_cnt == DRAIN_LAST) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
`endif
        default: begin
          state      <= S_IDLE;
          core_reset <= '1;
          busy       <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed self-checking bench for mips_run_ctrl (2 cores, 4-cycle hold, watchdog 100).
module tb_mips_run_ctrl;
  localparam int NUM_CH = 2;
`ifdef HALT_DRAIN_EN
  localparam int DR = 5;
`else
  localparam int DR = 0;
`endif

  logic              clk, reset, start;
  logic [NUM_CH-1:0] halt_i, core_reset, halted;
  logic [31:0]       cycle_count;
  logic              busy, done, timeout;
  int                n_chk = 0;
  int                n_fail = 0;

  mips_run_ctrl #(
    .NUM_CH(NUM_CH), .RESET_CYCLES(4), .MAX_CYCLES(100), .CNT_W(32), .DRAIN_CYCLES(5)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .halt_i(halt_i),
    .core_reset(core_reset), .cycle_count(cycle_count), .halted(halted),
    .busy(busy), .done(done), .timeout(timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start pulse plus four hold edges; leaves the controller in RUN with count 0.
  task automatic launch_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("launch_busy", busy, 1);
    chk("launch_cnt", cycle_count, 0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("hold_core_reset", core_reset, (k < 4) ? 32'd3 : 32'd0);
    end
    chk("run_cnt0", cycle_count, 0);
  endtask

  // After the edge that saw all halts: optional drain, then DONE.
  task automatic expect_done(input int cnt_at_halt);
    if (DR != 0) begin
      chk("drain_busy", busy, 1);
      chk("drain_done", done, 0);
      repeat (DR) tick();
    end
    chk("done", done, 1);
    chk("done_timeout", timeout, 0);
    chk("done_busy", busy, 0);
    chk("done_core_reset", core_reset, 0);
    chk("done_cnt", cycle_count, cnt_at_halt + 1 + DR);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; halt_i = '0;

    // 1: async reset with no clock edge
    #2 reset = 1'b1;
    #1;
    chk("rst_core_reset", core_reset, 3);
    chk("rst_cnt", cycle_count, 0);
    chk("rst_halted", halted, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    tick();
    reset = 1'b0;
    tick();
    launch_run();

    // 2: staggered halts
    repeat (10) tick();
    chk("cnt10", cycle_count, 10);
    halt_i = 2'b01;
    tick();
    halt_i = 2'b00;
    chk("halted01", halted, 1);
    chk("not_done", done, 0);
    repeat (9) tick();
    chk("cnt20", cycle_count, 20);
    halt_i = 2'b10;
    tick();
    halt_i = 2'b00;
    chk("halted11", halted, 3);
    expect_done(20);
    repeat (3) tick();
    chk("done_frozen", cycle_count, 21 + DR);

    // 3: watchdog
    launch_run();
    chk("restart_halted", halted, 0);
    chk("restart_done", done, 0);
    repeat (99) tick();
    chk("cnt99", cycle_count, 99);
    chk("pre_timeout", timeout, 0);
    tick();
    chk("timeout", timeout, 1);
    chk("to_cnt", cycle_count, 100);
    chk("to_core_reset", core_reset, 3);
    chk("to_done", done, 0);
    chk("to_busy", busy, 0);
    repeat (2) tick();
    chk("to_frozen", cycle_count, 100);

    // 4: halt and watchdog on the same cycle
    launch_run();
    chk("restart_timeout", timeout, 0);
    repeat (99) tick();
    halt_i = 2'b11;
    tick();
    halt_i = 2'b00;
    expect_done(99);

    // 5: reset mid-run, then restart with halts ignored during hold
    launch_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_ignored", cycle_count, 1);
    repeat (49) tick();
    chk("cnt50", cycle_count, 50);
    #2 reset = 1'b1;
    #1;
    chk("mid_core_reset", core_reset, 3);
    chk("mid_cnt", cycle_count, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    #1 reset = 1'b0;
    repeat (2) tick();
    chk("idle_busy", busy, 0);
    halt_i = 2'b11;
    launch_run();
    halt_i = 2'b00;
    chk("hold_halt_ignored", halted, 0);
    chk("hold_done", done, 0);

`ifdef HALT_DRAIN_EN
    // 6: drain after simultaneous halt, then restart from DONE
    repeat (30) tick();
    halt_i = 2'b11;
    tick();
    halt_i = 2'b00;
    chk("drain_cnt31", cycle_count, 31);
    repeat (4) tick();
    chk("drain_not_yet", done, 0);
    tick();
    chk("drain_done", done, 1);
    chk("drain_cnt36", cycle_count, 36);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("redo_busy", busy, 1);
    chk("redo_core_reset", core_reset, 3);
    chk("redo_cnt", cycle_count, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_run_ctrl.md
Name: mips_run_ctrl

Overview:
- Parametrised run controller for the MIPS32 pipelined core simulation and bring-up environment.
- Sequences per-core reset release, counts run cycles, detects program completion from per-core halt flags, and flags a watchdog timeout.
- Successor to the fixed clock/reset stimulus: it generalises reset hold length, run limit and core count, and adds completion and timeout detection, which the fixed stimulus lacks.
- Sits between the environment's clock/reset source and NUM_CH core instances.

Parameters:
- NUM_CH, 1, number of cores controlled (halt inputs and core resets).
- RESET_CYCLES, 2, clock cycles core_reset stays high after start; legal range 1 or more.
- MAX_CYCLES, 1000, watchdog limit in RUN cycles; 0 disables the watchdog.
- CNT_W, 32, width of the cycle counter; must hold MAX_CYCLES.
- DRAIN_CYCLES, 5, post-halt drain length; used only with HALT_DRAIN_EN.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset of this block.
- start  input  1  single-cycle pulse that begins a run; honoured in IDLE, DONE and TIMEOUT.
- halt_i  input  NUM_CH  per-core halt flag, level or pulse.
- core_reset  output  NUM_CH  per-core reset, active-high, registered, all bits identical.
- cycle_count  output  CNT_W  RUN cycles elapsed.
- halted  output  NUM_CH  sticky per-core halt-seen flags.
- busy  output  1  high in HOLD, RUN or DRAIN.
- done  output  1  all cores halted; level output.
- timeout  output  1  watchdog expired; level output.

Behaviour:
- Async reset values:
  - state = IDLE; core_reset = all 1s.
  - cycle_count = 0; hold counter = 0; halted = 0.
  - busy, done, timeout = 0.
  - All outputs are registered, so reset takes effect immediately with no clock.
- IDLE:
  - core_reset = all 1s.
  - start -> HOLD; clears cycle_count, halted, done, timeout and the hold counter.
- HOLD:
  - The hold counter increments each cycle.
  - When the counter equals RESET_CYCLES-1 -> RUN, and core_reset drops to 0 on that same edge.
  - Net effect: core_reset is high for exactly RESET_CYCLES edges after the start edge.
  - halt_i is ignored in HOLD.
- RUN:
  - cycle_count increments by 1 every cycle.
  - halted[i] is set on any cycle where halt_i[i] = 1; it never clears in RUN.
  - all_halt = AND of (halted OR halt_i).
  - all_halt -> DONE, with done = 1 on the next edge.
  - Otherwise, if MAX_CYCLES != 0 and cycle_count == MAX_CYCLES-1 -> TIMEOUT.
  - If all_halt and the watchdog fire on the same cycle, halt wins: go to DONE, timeout stays 0.
- DONE:
  - core_reset stays 0, so cores are left in their halted state for register/memory inspection.
  - cycle_count is frozen.
- TIMEOUT:
  - core_reset re-asserts to all 1s on the entry edge.
  - cycle_count is frozen at MAX_CYCLES.
- Restart:
  - start in DONE or TIMEOUT -> HOLD, with the same clears as from IDLE.
  - start in HOLD, RUN or DRAIN is ignored.
- busy = 1 exactly in HOLD, RUN and DRAIN.
- cycle_count wraps at 2^CNT_W only when MAX_CYCLES = 0; no saturation logic.
- Reset mid-run (any state): immediate return to IDLE values; no partial flags survive.

Optional Feature:
- Macro: HALT_DRAIN_EN.
- Defined:
  - all_halt in RUN -> DRAIN instead of DONE.
  - DRAIN runs for DRAIN_CYCLES cycles; cycle_count keeps incrementing; core_reset stays 0.
  - When DRAIN completes -> DONE.
  - The watchdog is not checked in DRAIN.
  - DRAIN_CYCLES = 0 behaves as if the macro were undefined.
  - Purpose: lets in-flight pipeline writebacks retire before done.
- Undefined:
  - No DRAIN state and no drain counter; RUN goes straight to DONE.
  - DRAIN_CYCLES is unused.

Test Plan (NUM_CH=2, RESET_CYCLES=4, MAX_CYCLES=100, CNT_W=32):
1. Assert reset between clock edges -> all outputs take reset values immediately; release reset, pulse start at edge 0 -> core_reset = 2'b11 through edges 1-3, 2'b00 after edge 4, busy = 1.
2. In RUN, pulse halt_i[0] at cycle_count=10 and halt_i[1] at cycle_count=20 -> halted = 01 then 11; done = 1 on the next edge; cycle_count frozen at 21; timeout = 0.
3. No halts -> timeout = 1 once cycle_count = 100; core_reset returns to 2'b11; done = 0; busy = 0.
4. halt_i = 2'b11 on the same cycle cycle_count == 99 -> done = 1, timeout = 0.
5. Assert reset mid-RUN at cycle_count=50 -> immediate IDLE values; a following start restarts with cycle_count = 0 and a 4-cycle hold.
6. With HALT_DRAIN_EN and DRAIN_CYCLES=5, both halt at cycle_count=30 -> done rises 5 cycles later with cycle_count = 36; start in DONE restarts HOLD.
